// File: rtl/uart_cmd_host_pkg.sv
// uart_cmd_host_pkg: shared opcodes, command/state enums and expected reply length
package uart_cmd_host_pkg;
    localparam logic [7:0] OP_REG_WR  = 8'hAA;
    localparam logic [7:0] OP_REG_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;
    typedef enum logic [1:0] {CMD_REG_WR, CMD_REG_RD, CMD_ALU_OPS, CMD_ALU_NOP} cmd_type_e;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;
    function automatic logic [1:0] rsp_count(cmd_type_e t);
        return t == CMD_REG_WR ? 2'd0 : t == CMD_REG_RD ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/uart_cmd_host_rsp_timer.sv
// uart_rsp_timer: 16-bit gap counter; hit marks the last idle cycle allowed before a timeout
module uart_rsp_timer #(
    parameter int LIMIT = 65535
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    logic [15:0] cnt_q;
    always_ff @(posedge CLK) begin
        if (RST || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 16'd1;
    end
    assign hit_o = en_i && cnt_q == 16'(LIMIT - 1);
endmodule

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: serializes one command frame to UART TX and gathers the reply bytes with a timeout
module uart_cmd_host
    import uart_cmd_host_pkg::*;
#(
    parameter int ADDR_SIZE      = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [ADDR_SIZE-1:0]     cmd_addr,
    input  logic [7:0]               cmd_wdata,
    input  logic [7:0]               cmd_op_a,
    input  logic [7:0]               cmd_op_b,
    input  logic [ALU_FUN_WIDTH-1:0] cmd_alu_fun,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rsp_valid,
    output logic [15:0]              rsp_data,
    output logic                     rsp_timeout
);
    state_e          state_q;
    logic [3:0][7:0] frame_d, frame_q;
    logic [1:0]      last_d, last_q, idx_q, idx_nxt, exp_q, rcnt_q, rcnt_nxt;
    logic [7:0]      addr8, fun8, tx_data_q;
    logic [15:0]     rsp_data_q;
    logic            tx_valid_q, rsp_timeout_q, hit;
    assign addr8    = 8'(cmd_addr);
    assign fun8     = 8'(cmd_alu_fun);
    assign idx_nxt  = idx_q + 2'd1;
    assign rcnt_nxt = rcnt_q + 2'd1;
    // frame[0] goes out first; last_d is the index of the final byte
    always_comb begin
        frame_d = '0;
        last_d  = 2'd1;
        case (cmd_type_e'(cmd_type))
            CMD_REG_WR:  begin frame_d = {8'h00, cmd_wdata, addr8, OP_REG_WR}; last_d = 2'd2; end
            CMD_REG_RD:  frame_d = {16'h0000, addr8, OP_REG_RD};
            CMD_ALU_OPS: begin frame_d = {fun8, cmd_op_b, cmd_op_a, OP_ALU_OPS}; last_d = 2'd3; end
            CMD_ALU_NOP: frame_d = {16'h0000, fun8, OP_ALU_NOP};
        endcase
    end
    uart_rsp_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .clr_i(state_q != S_WAIT || rx_valid),
        .en_i (state_q == S_WAIT),
        .hit_o(hit)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            frame_q       <= '0;
            last_q        <= '0;
            idx_q         <= '0;
            exp_q         <= '0;
            rcnt_q        <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    state_q       <= S_SEND;
                    frame_q       <= frame_d;
                    last_q        <= last_d;
                    exp_q         <= rsp_count(cmd_type_e'(cmd_type));
                    idx_q         <= '0;
                    rcnt_q        <= '0;
                    tx_valid_q    <= 1'b1;
                    tx_data_q     <= frame_d[0];
                    rsp_data_q    <= '0;
                    rsp_timeout_q <= 1'b0;
                end
                S_SEND: if (tx_ready) begin
                    if (idx_q == last_q) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= exp_q != 2'd0 ? S_WAIT : S_DONE;
                    end else begin
                        idx_q     <= idx_nxt;
                        tx_data_q <= frame_q[idx_nxt];
                    end
                end
                // a byte arriving on the limit cycle is taken in preference to the timeout
                S_WAIT: if (rx_valid) begin
                    rsp_data_q <= rcnt_q == 2'd0 ? {rsp_data_q[15:8], rx_data} : {rx_data, rsp_data_q[7:0]};
                    rcnt_q     <= rcnt_nxt;
                    if (rcnt_nxt == exp_q) state_q <= S_DONE;
                end else if (hit) begin
                    rsp_timeout_q <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: state_q <= S_IDLE;
            endcase
        end
    end
    assign cmd_ready   = state_q == S_IDLE;
    assign rsp_valid   = state_q == S_DONE;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
endmodule
